// File: rtl/image_memory_simd_wr_port_if.sv
// Lane-side write bus, flush handshake and BRAM write port of the SIMD write port.
interface image_memory_simd_wr_port_if #(
  parameter int N = 4,
  parameter int A = 18
);
  logic [N-1:0]        wr_req;
  logic [N-1:0][A-1:0] wr_addr;
  logic [N-1:0][7:0]   wr_data;
  logic [N-1:0]        wr_ready;
  logic                flush;
  logic                flush_done;
  logic                idle;
  logic                mem_we;
  logic [A-1:0]        mem_addr;
  logic [7:0]          mem_wdata;

  modport master (
    output wr_req, wr_addr, wr_data, flush,
    input  wr_ready, flush_done, idle, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, flush,
    output wr_ready, flush_done, idle, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/image_memory_simd_wr_port.sv
// N-lane SIMD write port: per-lane line buffers coalesce pixel writes and drain
// one byte per cycle into the single-port image BRAM under a round-robin arbiter.
module image_memory_simd_wr_port #(
  parameter int IMG_W     = 512,
  parameter int IMG_H     = 512,
  parameter int N         = 4,
  parameter int LINE_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  image_memory_simd_wr_port_if.slave  bus
);
  localparam int A  = $clog2(IMG_W * IMG_H);
  localparam int O  = $clog2(LINE_SIZE);
  localparam int TW = A - O;
  localparam int LW = $clog2(N);

  typedef enum logic [1:0] {COLLECT, WAIT_ARB, DRAIN} lane_state_t;

  lane_state_t               st       [N];
  lane_state_t               st_nxt   [N];
  logic [LINE_SIZE-1:0][7:0] data     [N];
  logic [LINE_SIZE-1:0][7:0] data_nxt [N];
  logic [LINE_SIZE-1:0]      mask     [N];
  logic [LINE_SIZE-1:0]      mask_nxt [N];
  logic [TW-1:0]             tag      [N];
  logic [TW-1:0]             tag_nxt  [N];

  logic [O-1:0]  drain_idx, drain_idx_nxt;
  logic [LW-1:0] drain_lane, drain_lane_nxt;
  logic [LW-1:0] arb_ptr, arb_ptr_nxt;
  logic          mem_busy, mem_busy_nxt;
  logic          flush_pending, flush_done_q, idle_q;
  logic          mem_we_q, mem_we_nxt;
  logic [A-1:0]  mem_addr_q, mem_addr_nxt;
  logic [7:0]    mem_wdata_q, mem_wdata_nxt;

  logic [N-1:0]  hit, ready, accept;
  logic          all_empty;
  logic          grant_found;
  logic [LW-1:0] grant_lane, cand_lane;
  int unsigned   cand;

  always_comb begin
    all_empty = !mem_busy;
    for (int unsigned i = 0; i < N; i++) begin
      hit[i]    = (mask[i] == '0) || (tag[i] == bus.wr_addr[i][A-1:O]);
      ready[i]  = !rst && !flush_pending && (st[i] == COLLECT) && hit[i];
      accept[i] = bus.wr_req[i] && ready[i];
      if (st[i] != COLLECT || mask[i] != '0) all_empty = 1'b0;
    end
  end

  assign bus.wr_ready = ready;

  // Round-robin search starts one past the lane that drained last.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    cand        = 0;
    cand_lane   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand      = (32'(arb_ptr) + k) % N;
      cand_lane = LW'(cand);
      if (!grant_found && st[cand_lane] == WAIT_ARB) begin
        grant_found = 1'b1;
        grant_lane  = cand_lane;
      end
    end
  end

  always_comb begin
    st_nxt         = st;
    data_nxt       = data;
    mask_nxt       = mask;
    tag_nxt        = tag;
    drain_idx_nxt  = drain_idx;
    drain_lane_nxt = drain_lane;
    arb_ptr_nxt    = arb_ptr;
    mem_busy_nxt   = mem_busy;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr_q;
    mem_wdata_nxt  = mem_wdata_q;

    for (int unsigned i = 0; i < N; i++) begin
      if (st[i] == COLLECT) begin
        if (accept[i]) begin
          data_nxt[i][bus.wr_addr[i][O-1:0]] = bus.wr_data[i];
          mask_nxt[i][bus.wr_addr[i][O-1:0]] = 1'b1;
          tag_nxt[i]                         = bus.wr_addr[i][A-1:O];
        end
        if (accept[i] && (&mask_nxt[i]))               st_nxt[i] = WAIT_ARB;
        else if (bus.wr_req[i] && !hit[i])             st_nxt[i] = WAIT_ARB;
        else if (flush_pending && mask[i] != '0)       st_nxt[i] = WAIT_ARB;
      end
    end

    // mem_busy implies exactly one lane in DRAIN, tracked by drain_lane.
    if (mem_busy) begin
      mem_we_nxt    = mask[drain_lane][drain_idx];
      mem_addr_nxt  = {tag[drain_lane], drain_idx};
      mem_wdata_nxt = data[drain_lane][drain_idx];
      drain_idx_nxt = drain_idx + 1'b1;
      if (drain_idx == O'(LINE_SIZE - 1)) begin
        mask_nxt[drain_lane] = '0;
        st_nxt[drain_lane]   = COLLECT;
        mem_busy_nxt         = 1'b0;
        arb_ptr_nxt          = drain_lane;
      end
    end else if (grant_found) begin
      st_nxt[grant_lane] = DRAIN;
      drain_idx_nxt      = '0;
      drain_lane_nxt     = grant_lane;
      mem_busy_nxt       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        st[i]   <= COLLECT;
        data[i] <= '0;
        mask[i] <= '0;
        tag[i]  <= '0;
      end
      drain_idx     <= '0;
      drain_lane    <= '0;
      arb_ptr       <= LW'(N - 1);
      mem_busy      <= 1'b0;
      flush_pending <= 1'b0;
      flush_done_q  <= 1'b0;
      idle_q        <= 1'b1;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        st[i]   <= st_nxt[i];
        data[i] <= data_nxt[i];
        mask[i] <= mask_nxt[i];
        tag[i]  <= tag_nxt[i];
      end
      drain_idx     <= drain_idx_nxt;
      drain_lane    <= drain_lane_nxt;
      arb_ptr       <= arb_ptr_nxt;
      mem_busy      <= mem_busy_nxt;
      flush_pending <= bus.flush || (flush_pending && !all_empty);
      flush_done_q  <= flush_pending && all_empty;
      idle_q        <= all_empty;
      mem_we_q      <= mem_we_nxt;
      mem_addr_q    <= mem_addr_nxt;
      mem_wdata_q   <= mem_wdata_nxt;
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.flush_done = flush_done_q;
  assign bus.idle       = idle_q;
endmodule

// File: tb/tb_image_memory_simd_wr_port.sv
// Bench for image_memory_simd_wr_port: write-vector table plus hand sequences;
// every BRAM write is matched against a queue of expected {addr, data}.
module tb_image_memory_simd_wr_port;
  localparam int IMG_W     = 512;
  localparam int IMG_H     = 512;
  localparam int N         = 4;
  localparam int LINE_SIZE = 8;
  localparam int A         = $clog2(IMG_W * IMG_H);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_memory_simd_wr_port_if #(.N(N), .A(A)) bus ();

  image_memory_simd_wr_port #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .N(N), .LINE_SIZE(LINE_SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int           lane;
    logic [A-1:0] addr;
    logic [7:0]   data;
    bit           exp_ready;
    bit           exp_mem;
  } wr_vec_t;

  typedef logic [A+7:0] mem_wr_t;

  wr_vec_t vecs [19];
  mem_wr_t exp_q [$];
  int      errors   = 0;
  int      checks   = 0;
  int      we_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every BRAM write must be the next expected one.
  always @(posedge clk) begin
    mem_wr_t e;
    #2;
    if (!rst && bus.mem_we) begin
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_unexpected: got write addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("mem_addr", 32'(bus.mem_addr), 32'(e[A+7:8]));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic apply_vec(input wr_vec_t v);
    bus.wr_req[v.lane]  = 1'b1;
    bus.wr_addr[v.lane] = v.addr;
    bus.wr_data[v.lane] = v.data;
    #1;
    chk($sformatf("ready_lane%0d_addr%0h", v.lane, v.addr), 32'(bus.wr_ready[v.lane]), 32'(v.exp_ready));
    if (v.exp_mem) exp_q.push_back({v.addr, v.data});
    @(negedge clk);
    bus.wr_req[v.lane] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!bus.idle && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.idle), 32'd1);
  endtask

  // idx: negedges after the flush edge until flush_done is seen (-1 if never).
  task automatic flush_and_wait(output int idx, output int pulses, output int ready_bad);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    idx       = -1;
    pulses    = 0;
    ready_bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.flush_done) begin
        pulses++;
        if (idx < 0) idx = j;
      end else if (idx < 0 && bus.wr_ready != '0) begin
        ready_bad++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int      idx, pulses, ready_bad, n, we0;
    wr_vec_t v;

    for (int k = 0; k < 8; k++) vecs[k] = '{0, A'(32'h100 + k), 8'(8'h10 + k), 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) vecs[8 + k] = '{2, A'(32'h400 + k), 8'(8'hC0 + k), 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) vecs[11 + k] = '{3, A'(32'h508 + k), 8'(8'hD0 + k), 1'b1, 1'b1};
    vecs[16] = '{0, A'(32'h605), 8'h11, 1'b1, 1'b0};
    vecs[17] = '{0, A'(32'h605), 8'h22, 1'b1, 1'b1};
    vecs[18] = '{1, A'(32'h203), 8'hAA, 1'b1, 1'b1};

    rst         = 1'b1;
    bus.wr_req  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.flush   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.wr_ready), 32'hF);

    // All four lanes fill a line on the same edges; drains go 0,1,2,3 with one bubble each.
    for (int l = 0; l < N; l++)
      for (int k = 0; k < LINE_SIZE; k++)
        exp_q.push_back({A'(l * 8 + k), 8'(8'h40 + l * 8 + k)});
    for (int k = 0; k < LINE_SIZE; k++) begin
      for (int l = 0; l < N; l++) begin
        bus.wr_req[l]  = 1'b1;
        bus.wr_addr[l] = A'(l * 8 + k);
        bus.wr_data[l] = 8'(8'h40 + l * 8 + k);
      end
      #1;
      chk("fill4_ready", 32'(bus.wr_ready), 32'hF);
      @(negedge clk);
    end
    bus.wr_req = '0;
    for (int j = 0; j < 36; j++) begin
      @(negedge clk);
      chk($sformatf("fill4_we_slot%0d", j), 32'(bus.mem_we), (j % 9 != 0) ? 32'd1 : 32'd0);
    end
    wait_idle("fill4_idle");

    // Lane 0 full line: writes start two edges after the last accept.
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);
    chk("line0_ready_low", 32'(bus.wr_ready[0]), 32'd0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("line0_we_slot%0d", j), 32'(bus.mem_we), (j >= 1 && j <= 8) ? 32'd1 : 32'd0);
      if (j == 8) chk("line0_ready_back", 32'(bus.wr_ready[0]), 32'd1);
    end
    wait_idle("line0_idle");

    // Eviction: a different tag forces a drain; the held request is then accepted.
    apply_vec(vecs[18]);
    we0 = we_count;
    bus.wr_req[1]  = 1'b1;
    bus.wr_addr[1] = A'(32'h300);
    bus.wr_data[1] = 8'h55;
    #1;
    chk("evict_ready_low", 32'(bus.wr_ready[1]), 32'd0);
    n = 0;
    while (!bus.wr_ready[1] && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("evict_wait_edges", 32'(n), 32'd10);
    chk("evict_we_count", 32'(we_count - we0), 32'd1);
    exp_q.push_back({A'(32'h300), 8'h55});
    @(negedge clk);
    bus.wr_req[1] = 1'b0;
    flush_and_wait(idx, pulses, ready_bad);
    chk("evict_flush_idx", 32'(idx), 32'd11);
    wait_idle("evict_idle");

    // Partial lines on lanes 2 and 3, drained by flush.
    for (int i = 8; i < 16; i++) apply_vec(vecs[i]);
    we0 = we_count;
    flush_and_wait(idx, pulses, ready_bad);
    chk("partial_flush_idx", 32'(idx), 32'd20);
    chk("partial_flush_pulses", 32'(pulses), 32'd1);
    chk("partial_ready_blocked", 32'(ready_bad), 32'd0);
    chk("partial_we_count", 32'(we_count - we0), 32'd8);
    chk("partial_idle", 32'(bus.idle), 32'd1);
    chk("partial_ready_after", 32'(bus.wr_ready), 32'hF);

    // Same offset rewritten: only the last value reaches memory.
    apply_vec(vecs[16]);
    apply_vec(vecs[17]);
    we0 = we_count;
    flush_and_wait(idx, pulses, ready_bad);
    chk("overwrite_we_count", 32'(we_count - we0), 32'd1);

    flush_and_wait(idx, pulses, ready_bad);
    chk("idle_flush_idx", 32'(idx), 32'd1);
    chk("idle_flush_pulses", 32'(pulses), 32'd1);

    // Reset while lane 0 is draining: only bytes already presented count.
    for (int k = 0; k < LINE_SIZE; k++) begin
      v = '{0, A'(32'h700 + k), 8'(8'h70 + k), 1'b1, (k < 3)};
      apply_vec(v);
    end
    repeat (4) @(negedge clk);
    chk("mid_drain_we", 32'(bus.mem_we), 32'd1);
    chk("mid_drain_addr", 32'(bus.mem_addr), 32'h702);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_rst_idle", 32'(bus.idle), 32'd1);
    chk("mid_rst_ready", 32'(bus.wr_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v = '{0, A'(32'h703), 8'h99, 1'b1, 1'b1};
    apply_vec(v);
    we0 = we_count;
    flush_and_wait(idx, pulses, ready_bad);
    chk("post_rst_we_count", 32'(we_count - we0), 32'd1);
    wait_idle("final_idle");
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_memory_simd_wr_port.md
# image_memory_simd_wr_port

N-lane SIMD write port that combines per-lane pixel writes into line-sized write buffers and drains them, one byte per cycle, into the single-port image BRAM under a round-robin arbiter. It is the write-side counterpart of the SIMD cached read port. It sits between the SIMD processing lanes and the `ImageMemory` write port (`we`, `addr`, `wr_data`).

## Interface
- IMG_W, 512, image width in pixels
- IMG_H, 512, image height in pixels
- N, 4, number of SIMD lanes (≥2)
- LINE_SIZE, 8, bytes per write buffer line (power of 2, ≥2)
- Derived: A = $clog2(IMG_W*IMG_H); O = $clog2(LINE_SIZE); tag = addr[A-1:O]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_req  in  1 [N]  lane write request
- wr_addr  in  A [N]  lane pixel address
- wr_data  in  8 [N]  lane pixel value
- wr_ready  out  1 [N]  combinational; a write is accepted on an edge where wr_req && wr_ready
- flush  in  1  single-cycle pulse: drain every non-empty buffer
- flush_done  out  1  registered one-cycle pulse when a flush completes
- idle  out  1  registered; all buffers empty and no drain in progress
- mem_we  out  1  registered BRAM write enable
- mem_addr  out  A  registered BRAM address
- mem_wdata  out  8  registered BRAM write data

## Operation
- Per-lane state: buffer data[LINE_SIZE], byte mask[LINE_SIZE], tag, FSM {COLLECT, WAIT_ARB, DRAIN}.
- COLLECT: wr_ready[i] = !rst && !flush_pending && (mask==0 || tag==wr_addr tag).
  - On accept: data[off] <= wr_data, mask[off] <= 1, tag <= wr_addr tag. Rewriting the same offset overwrites.
  - If the accept makes mask all-ones: go to WAIT_ARB on the same edge.
  - wr_req to a different tag while mask!=0: not accepted. Go to WAIT_ARB (eviction). The requester holds its request and it is accepted after the drain.
  - flush_pending && mask!=0: go to WAIT_ARB.
- Arbiter: a single mem_busy flag and arb_ptr. Search order arb_ptr+1, arb_ptr+2, … mod N. The first lane found in WAIT_ARB is granted when !mem_busy. The grant edge sets state DRAIN, drain_idx 0 and mem_busy 1. arb_ptr resets to N-1, so lane 0 has first priority.
- DRAIN, edge with drain_idx k:
  - mem_we <= mask[k]; mem_addr <= {tag, k}; mem_wdata <= data[k].
  - Bytes with mask=0 produce mem_we=0 and are never written.
  - At k = LINE_SIZE-1, the same edge also clears mask, returns to COLLECT, clears mem_busy and sets arb_ptr <= lane.
- mem_we is 0 on every edge with no active drain.
- Only one lane drives memory at a time. Cross-lane writes to the same address land in drain order.
- flush: the pulse sets flush_pending. It clears on the first edge where all lanes are in COLLECT with mask==0 and !mem_busy. That edge pulses flush_done. flush while already idle gives flush_done on the next edge.
- idle <= all masks zero && all lanes COLLECT && !mem_busy.

## Timing
- Reset values:
  - all lanes COLLECT, masks 0
  - mem_we/mem_addr/mem_wdata 0
  - flush_pending 0, flush_done 0, idle 1
  - arb_ptr N-1, mem_busy 0
  - wr_ready 0 while rst high
- Write accept: 0 cycles (combinational ready, registered capture).
- Full-line latency: last byte accepted at edge T; grant at T+1; mem outputs carry offsets 0..LINE_SIZE-1 after edges T+2..T+1+LINE_SIZE; the lane is ready again after T+1+LINE_SIZE.
- There is one bubble edge between consecutive drains (grant edge).
- A lane in WAIT_ARB/DRAIN holds wr_ready low. The other lanes keep accepting hits.
- Reset mid-drain: buffers are discarded. Only bytes already presented on mem_we are written.

## Test plan
- Lane 0 writes 0x10..0x17 to addr 0x100..0x107 -> mem_we high 8 consecutive cycles, addr 0x100..0x107, data 0x10..0x17, starting 2 edges after the last accept; idle returns to 1.
- Lane 1 writes 0xAA to 0x203, then requests 0x300 -> eviction drain: exactly one mem_we at 0x203 with data 0xAA over 8 drain cycles; then the 0x300 write is accepted.
- All 4 lanes fill lines at 0x000/0x008/0x010/0x018 on the same edge -> drains in order lanes 0,1,2,3, each 8 cycles plus a 1-edge bubble; no overlapping mem_we.
- Lanes 2 and 3 hold partial lines (3 and 5 bytes) and flush pulses -> 8 total mem_we; wr_ready low for all lanes until flush_done pulses once; idle=1.
- Assert rst during a lane-0 drain at k=3 -> mem_we 0 immediately; all outputs at reset values; the next write to the old tag starts with an empty mask.
- Write to offset 5 twice (0x11, then 0x22) then flush -> a single mem_we at offset 5 with data 0x22.
